// File: rtl/retire_stage.sv
// ---------------------------------------------------------------------------
// retire_stage
//
// N-wide in-order commit stage placed directly after the ROB. Each cycle it
// looks at the oldest outputs_valid ROB head entries and retires the longest
// completed prefix. A halting or mispredicting entry retires but closes the
// group. Retiring entries update the architectural map table (AMT), and their
// T_old registers are handed back to the free list. The stage also sequences
// the one-cycle rollback pulse and the sticky halt.
//
// Configuration macros:
//   N                - default retire width when not supplied (4)
//   PHYS_REG_SZ      - default physical register count when not supplied (64)
//   RETIRE_STATS_EN  - when defined, adds the 32-bit retired_count output
//
// Ports:
//   clock          in   single clock, all state on posedge
//   reset          in   asynchronous, active-low
//   rob_outputs    in   N ROB head entries, slot 0 oldest
//   outputs_valid  in   number of valid head slots
//   complete_list  in   bit p set = physical reg p has been written back
//   num_retiring   out  combinational count of slots the ROB pops this cycle
//   free_valid     out  registered count of valid free_regs slots
//   free_regs      out  registered T_old values being freed, packed from 0
//   arch_map       out  registered AMT contents
//   rollback       out  registered one-cycle flush request
//   halted         out  registered, sticky until reset
//   retired_count  out  (RETIRE_STATS_EN only) total retired, wraps at 2^32
// ---------------------------------------------------------------------------

`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

`ifndef RETIRE_STAGE_TYPES_DEFINED
`define RETIRE_STAGE_TYPES_DEFINED
localparam int RETIRE_PRB = $clog2(`PHYS_REG_SZ);

typedef struct packed {
  logic [RETIRE_PRB-1:0] T_new;
  logic [RETIRE_PRB-1:0] T_old;
  logic [4:0]            dest_reg;
  logic                  halt;
  logic                  mispredict;
} ROB_EXIT_PACKET;
`endif

module retire_stage #(
  parameter  int N               = `N,
  parameter  int PHYS_REGS       = `PHYS_REG_SZ,
  parameter  int ARCH_REGS       = 32,
  localparam int NUM_SCALAR_BITS = $clog2(N + 1),
  localparam int PRB             = $clog2(PHYS_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  ROB_EXIT_PACKET             rob_outputs [N],
  input  logic [NUM_SCALAR_BITS-1:0] outputs_valid,
  input  logic [PHYS_REGS-1:0]       complete_list,
  output logic [NUM_SCALAR_BITS-1:0] num_retiring,
  output logic [NUM_SCALAR_BITS-1:0] free_valid,
  output logic [PRB-1:0]             free_regs [N],
  output logic [PRB-1:0]             arch_map [ARCH_REGS],
  output logic                       rollback,
  output logic                       halted
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]                retired_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [PRB-1:0]             amt_q [ARCH_REGS];
  logic [PRB-1:0]             amt_d [ARCH_REGS];
  logic [PRB-1:0]             free_regs_q [N];
  logic [PRB-1:0]             free_regs_d [N];
  logic [NUM_SCALAR_BITS-1:0] free_valid_q, free_valid_d;
  logic                       rollback_q, rollback_d;
  logic                       halted_q, halted_d;
  logic [NUM_SCALAR_BITS-1:0] retire_cnt;
  logic                       group_open;
  logic                       take_halt;
  logic                       take_mispredict;

  // Retire selection: walk slots oldest-first while the group is still open,
  // applying AMT writes in age order so the youngest same-dest write wins.
  always_comb begin
    retire_cnt      = '0;
    group_open      = (state_q == ST_RUN);
    take_halt       = 1'b0;
    take_mispredict = 1'b0;
    amt_d           = amt_q;
    free_valid_d    = '0;
    for (int k = 0; k < N; k++) begin
      free_regs_d[k] = '0;
    end

    for (int i = 0; i < N; i++) begin
      if (group_open && (NUM_SCALAR_BITS'(i) < outputs_valid) &&
          complete_list[rob_outputs[i].T_new]) begin
        retire_cnt = retire_cnt + NUM_SCALAR_BITS'(1);
        if (rob_outputs[i].dest_reg != 5'd0) begin
          for (int a = 0; a < ARCH_REGS; a++) begin
            amt_d[a] = (rob_outputs[i].dest_reg == 5'(a)) ? rob_outputs[i].T_new : amt_d[a];
          end
          // Freed registers are packed densely from slot 0.
          for (int k = 0; k < N; k++) begin
            free_regs_d[k] = (free_valid_d == NUM_SCALAR_BITS'(k)) ? rob_outputs[i].T_old
                                                                   : free_regs_d[k];
          end
          free_valid_d = free_valid_d + NUM_SCALAR_BITS'(1);
        end else begin
          free_valid_d = free_valid_d;
        end
        // A control-flow event retires itself but nothing younger.
        if (rob_outputs[i].halt) begin
          take_halt  = 1'b1;
          group_open = 1'b0;
        end else if (rob_outputs[i].mispredict) begin
          take_mispredict = 1'b1;
          group_open      = 1'b0;
        end else begin
          group_open = group_open;
        end
      end else begin
        group_open = 1'b0;
      end
    end
  end

  assign num_retiring = retire_cnt;

  // Next-state logic; halt outranks mispredict on the same slot.
  always_comb begin
    state_d    = state_q;
    rollback_d = 1'b0;
    halted_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (take_halt) begin
          state_d = ST_HALTED;
        end else if (take_mispredict) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH:  state_d = ST_RUN;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
    rollback_d = (state_d == ST_FLUSH);
    halted_d   = (state_d == ST_HALTED);
  end

  // State, AMT and free-list report registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      free_valid_q <= '0;
      rollback_q   <= 1'b0;
      halted_q     <= 1'b0;
      for (int a = 0; a < ARCH_REGS; a++) begin
        amt_q[a] <= PRB'(a);
      end
      for (int k = 0; k < N; k++) begin
        free_regs_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      free_valid_q <= free_valid_d;
      rollback_q   <= rollback_d;
      halted_q     <= halted_d;
      amt_q        <= amt_d;
      free_regs_q  <= free_regs_d;
    end
  end

  assign free_valid = free_valid_q;
  assign free_regs  = free_regs_q;
  assign arch_map   = amt_q;
  assign rollback   = rollback_q;
  assign halted     = halted_q;

`ifdef RETIRE_STATS_EN
  logic [31:0] retired_count_q, retired_count_d;

  // Running total of retired instructions; naturally holds while halted.
  always_comb begin
    retired_count_d = retired_count_q + 32'(retire_cnt);
  end

  // Statistics counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count_q <= 32'd0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the commit rules.
module tb_retire_stage;

  localparam int N    = 4;
  localparam int PHYS = 64;
  localparam int ARCH = 32;
  localparam int NSB  = 3;
  localparam int PRB  = 6;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  ROB_EXIT_PACKET       rob_outputs [N];
  logic [NSB-1:0]       outputs_valid;
  logic [PHYS-1:0]      complete_list;
  logic [NSB-1:0]       num_retiring;
  logic [NSB-1:0]       free_valid;
  logic [PRB-1:0]       free_regs [N];
  logic [PRB-1:0]       arch_map [ARCH];
  logic                 rollback;
  logic                 halted;
`ifdef RETIRE_STATS_EN
  logic [31:0]          retired_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  retire_stage #(.N(N), .PHYS_REGS(PHYS), .ARCH_REGS(ARCH)) dut (
    .clock         (clock),
    .reset         (reset),
    .rob_outputs   (rob_outputs),
    .outputs_valid (outputs_valid),
    .complete_list (complete_list),
    .num_retiring  (num_retiring),
    .free_valid    (free_valid),
    .free_regs     (free_regs),
    .arch_map      (arch_map),
    .rollback      (rollback),
    .halted        (halted)
`ifdef RETIRE_STATS_EN
    ,
    .retired_count (retired_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_amt [ARCH];
  int          m_free [$];
  bit          m_rollback;
  bit          m_halted;
  logic [31:0] m_count;

  // Length of the retiring prefix under the current inputs.
  function automatic int exp_retire();
    int n = 0;
    if (m_rollback || m_halted) return 0;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(outputs_valid)) break;
      if (!complete_list[rob_outputs[i].T_new]) break;
      n++;
      if (rob_outputs[i].halt || rob_outputs[i].mispredict) break;
    end
    return n;
  endfunction

  int m_n;
  bit m_fl, m_hl;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < ARCH; a++) m_amt[a] = a;
      m_free.delete();
      m_rollback = 1'b0;
      m_halted   = 1'b0;
      m_count    = 32'd0;
    end else begin
      m_n  = exp_retire();
      m_fl = 1'b0;
      m_hl = 1'b0;
      m_free.delete();
      for (int i = 0; i < m_n; i++) begin
        if (rob_outputs[i].dest_reg != 5'd0) begin
          m_amt[rob_outputs[i].dest_reg] = int'(rob_outputs[i].T_new);
          m_free.push_back(int'(rob_outputs[i].T_old));
        end
        if (rob_outputs[i].halt) m_hl = 1'b1;
        else if (rob_outputs[i].mispredict) m_fl = 1'b1;
      end
      m_count    = m_count + 32'(m_n);
      m_rollback = m_fl;
      m_halted   = m_halted | m_hl;
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clock) begin
    check("num_retiring", 32'(num_retiring), 32'(exp_retire()));
    check("free_valid", 32'(free_valid), 32'(m_free.size()));
    for (int k = 0; k < m_free.size(); k++)
      check("free_regs", 32'(free_regs[k]), 32'(m_free[k]));
    for (int a = 0; a < ARCH; a++)
      check("arch_map", 32'(arch_map[a]), 32'(m_amt[a]));
    check("rollback", 32'(rollback), 32'(m_rollback));
    check("halted", 32'(halted), 32'(m_halted));
`ifdef RETIRE_STATS_EN
    check("retired_count", retired_count, m_count);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    outputs_valid = '0;
    complete_list = '0;
    for (int i = 0; i < N; i++) rob_outputs[i] = '0;
  endtask

  task automatic set_slot(input int i, input int tn, input int to, input int dr,
                          input bit h, input bit m);
    rob_outputs[i].T_new      = PRB'(tn);
    rob_outputs[i].T_old      = PRB'(to);
    rob_outputs[i].dest_reg   = 5'(dr);
    rob_outputs[i].halt       = h;
    rob_outputs[i].mispredict = m;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    #12;
    // Reset state
    check("rst_arch_map5", 32'(arch_map[5]), 32'd5);
    check("rst_free_valid", 32'(free_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rollback", 32'(rollback), 32'd0);
    check("rst_num_retiring", 32'(num_retiring), 32'd0);
    reset = 1'b1;

    // Full-width retire
    next_cycle();
    outputs_valid = 3'd4;
    for (int i = 0; i < N; i++) begin
      set_slot(i, 10 + i, 40 + i, i + 1, 1'b0, 1'b0);
      complete_list[10 + i] = 1'b1;
    end
    #1 check("full_num_retiring", 32'(num_retiring), 32'd4);
    next_cycle();
    check("full_free_valid", 32'(free_valid), 32'd4);
    for (int i = 0; i < N; i++) begin
      check("full_free_regs", 32'(free_regs[i]), 32'(40 + i));
      check("full_arch_map", 32'(arch_map[i + 1]), 32'(10 + i));
    end
    drive_idle();

    // Slot 1 incomplete stops the group
    next_cycle();
    outputs_valid = 3'd4;
    for (int i = 0; i < N; i++) set_slot(i, 20 + i, 30 + i, 5 + i, 1'b0, 1'b0);
    complete_list[20] = 1'b1;
    complete_list[22] = 1'b1;
    complete_list[23] = 1'b1;
    #1 check("partial_num_retiring", 32'(num_retiring), 32'd1);
    next_cycle();
    outputs_valid = 3'd3;
    for (int i = 0; i < 3; i++) set_slot(i, 21 + i, 31 + i, 6 + i, 1'b0, 1'b0);
    set_slot(3, 0, 0, 0, 1'b0, 1'b0);
    complete_list[21] = 1'b1;
    #1 check("resume_num_retiring", 32'(num_retiring), 32'd3);
    next_cycle();
    check("resume_free_valid", 32'(free_valid), 32'd3);
    check("resume_free_regs0", 32'(free_regs[0]), 32'd31);
    check("resume_arch_map8", 32'(arch_map[8]), 32'd23);
    drive_idle();

    // Mispredict on slot 0
    next_cycle();
    outputs_valid = 3'd2;
    set_slot(0, 24, 34, 9, 1'b0, 1'b1);
    set_slot(1, 25, 35, 10, 1'b0, 1'b0);
    complete_list[24] = 1'b1;
    complete_list[25] = 1'b1;
    #1 check("mp_num_retiring", 32'(num_retiring), 32'd1);
    next_cycle();
    outputs_valid = 3'd1;
    set_slot(0, 25, 35, 10, 1'b0, 1'b0);
    set_slot(1, 0, 0, 0, 1'b0, 1'b0);
    #1;
    check("mp_rollback", 32'(rollback), 32'd1);
    check("mp_flush_num_retiring", 32'(num_retiring), 32'd0);
    check("mp_arch_map9", 32'(arch_map[9]), 32'd24);
    next_cycle();
    check("mp_rollback_clear", 32'(rollback), 32'd0);
    check("mp_resume_num_retiring", 32'(num_retiring), 32'd1);
    next_cycle();
    check("mp_arch_map10", 32'(arch_map[10]), 32'd25);
    drive_idle();

    // Two writes to the same dest_reg
    next_cycle();
    outputs_valid = 3'd2;
    set_slot(0, 50, 20, 7, 1'b0, 1'b0);
    set_slot(1, 51, 50, 7, 1'b0, 1'b0);
    complete_list[50] = 1'b1;
    complete_list[51] = 1'b1;
    next_cycle();
    check("dup_arch_map7", 32'(arch_map[7]), 32'd51);
    check("dup_free_valid", 32'(free_valid), 32'd2);
    check("dup_free_regs0", 32'(free_regs[0]), 32'd20);
    check("dup_free_regs1", 32'(free_regs[1]), 32'd50);
    drive_idle();

    // Halt, then asynchronous reset clears it
    next_cycle();
    outputs_valid = 3'd2;
    set_slot(0, 60, 12, 3, 1'b1, 1'b0);
    set_slot(1, 61, 13, 4, 1'b0, 1'b0);
    complete_list = '1;
    #1 check("halt_num_retiring", 32'(num_retiring), 32'd1);
    next_cycle();
    outputs_valid = 3'd4;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_arch_map3", 32'(arch_map[3]), 32'd60);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      check("halt_hold_num_retiring", 32'(num_retiring), 32'd0);
    end
    #1 reset = 1'b0;
    #1;
    check("async_halted_clear", 32'(halted), 32'd0);
    check("async_arch_map3", 32'(arch_map[3]), 32'd3);
    reset = 1'b1;
    drive_idle();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      outputs_valid = NSB'($urandom_range(0, N));
      complete_list = ~({$urandom, $urandom} & {$urandom, $urandom});
      for (int i = 0; i < N; i++) begin
        set_slot(i, $urandom_range(0, PHYS - 1), $urandom_range(0, PHYS - 1),
                 ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
      end
      if ((halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end

    next_cycle();
    drive_idle();
    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
